filt_drv: RTL and testbench

Line driver that turns single-cycle commands into a level waveform in which every level persists for at least HOLD clock cycles. A downstream N-consecutive-sample glitch filter (e.g. the 3-sample hysteresis filter, reset output 0) therefore passes every commanded transition. Sits on the transmit side of a filtered single-wire control line, in front of the wire or a loopback filter instance.

---
 rtl/filt_pkg.sv | 19 +
 rtl/filt_drv.sv | 128 ++++++++++++
 tb/tb_filt_drv.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/filt_pkg.sv
// Shared definitions for the filtered single-wire control line: command
// encodings and the driver state enum.
package filt_pkg;

    localparam logic [1:0] OP_SET0  = 2'd0;
    localparam logic [1:0] OP_SET1  = 2'd1;
    localparam logic [1:0] OP_PULSE = 2'd2;
    localparam logic [1:0] OP_NOP   = 2'd3;

    // ST_P_PRE is the forced low phase that precedes a pulse started while the line is high
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HOLD,
        ST_P_PRE,
        ST_P_HI,
        ST_P_LO
    } state_e;

endpackage

// File: rtl/filt_drv.sv
// Line driver: turns single-cycle commands into a level waveform in which
// each driven level persists for at least HOLD cycles. A downstream
// N-sample glitch filter therefore passes every commanded transition.
module filt_drv
    import filt_pkg::*;
#(
    parameter int unsigned HOLD = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    input  logic [1:0] cmd_op,
    output logic       cmd_ready,
    output logic       o,
    output logic       busy,
    output logic       done
);

    localparam int unsigned  CW       = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(HOLD - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    state_e        r_state, w_state_d;
    logic [CW-1:0] r_cnt, w_cnt_d;
    logic          r_o, w_o_d;
    logic          r_done, w_done_d;
    logic          w_cnt_zero;
    logic          w_take;

    assign w_cnt_zero = (r_cnt == '0);
    assign cmd_ready  = (r_state == ST_IDLE) ||
                        (((r_state == ST_HOLD) || (r_state == ST_P_LO)) && w_cnt_zero);
    assign busy       = (r_state != ST_IDLE);
    assign o          = r_o;
    assign done       = r_done;

    // Next-state: hold-counter sequencing, then command processing as from idle
    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_o_d     = r_o;
        w_done_d  = 1'b0;
        w_take    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_take = cmd_valid;
            end
            ST_HOLD, ST_P_LO: begin
                if (!w_cnt_zero) begin
                    w_cnt_d = r_cnt - CNT_ONE;
                    // Raised on the edge reaching zero so done coincides with cmd_ready
                    if (r_cnt == CNT_ONE) begin
                        w_done_d = 1'b1;
                    end
                end else begin
                    w_state_d = ST_IDLE;
                    w_take    = cmd_valid;
                end
            end
            ST_P_PRE: begin
                if (!w_cnt_zero) begin
                    w_cnt_d = r_cnt - CNT_ONE;
                end else begin
                    w_o_d     = 1'b1;
                    w_cnt_d   = CNT_LOAD;
                    w_state_d = ST_P_HI;
                end
            end
            ST_P_HI: begin
                if (!w_cnt_zero) begin
                    w_cnt_d = r_cnt - CNT_ONE;
                end else begin
                    w_o_d     = 1'b0;
                    w_cnt_d   = CNT_LOAD;
                    w_state_d = ST_P_LO;
                end
            end
            default: begin
                w_state_d = ST_IDLE;
                w_cnt_d   = '0;
            end
        endcase

        if (w_take) begin
            unique case (cmd_op)
                OP_SET0, OP_SET1: begin
                    if (cmd_op[0] != r_o) begin
                        w_o_d     = cmd_op[0];
                        w_cnt_d   = CNT_LOAD;
                        w_state_d = ST_HOLD;
                    end else begin
                        w_state_d = ST_IDLE;
                        w_cnt_d   = '0;
                        w_done_d  = 1'b1;
                    end
                end
                OP_PULSE: begin
                    // A pulse from a high line first needs a full low phase
                    w_o_d     = ~r_o;
                    w_cnt_d   = CNT_LOAD;
                    w_state_d = r_o ? ST_P_PRE : ST_P_HI;
                end
                OP_NOP: begin
                    w_state_d = ST_IDLE;
                    w_cnt_d   = '0;
                    w_done_d  = 1'b1;
                end
            endcase
        end
    end

    // State, counter, line and completion registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_o     <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_o     <= w_o_d;
            r_done  <= w_done_d;
        end
    end

endmodule

// File: tb/tb_filt_drv.sv
// Directed bench for filt_drv (HOLD=4) with a 3-sample hysteresis filter
// modelled in the bench as the loopback observer on o.
module tb_filt_drv;
    import filt_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_op = OP_NOP;
    logic       cmd_ready, o, busy, done;

    logic [1:0] r_hist;
    logic       y;

    int n_checks = 0;
    int n_fail   = 0;

    filt_drv #(.HOLD(4)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .cmd_valid(cmd_valid),
        .cmd_op   (cmd_op),
        .cmd_ready(cmd_ready),
        .o        (o),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Loopback filter: output follows the line once three samples agree
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hist <= 2'b00;
            y      <= 1'b0;
        end else begin
            r_hist <= {r_hist[0], o};
            if (&{r_hist, o}) y <= 1'b1;
            else if (~|{r_hist, o}) y <= 1'b0;
        end
    end

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic eo, input logic er,
                           input logic eb, input logic ed);
        chk({tag, ".o"}, o, eo);
        chk({tag, ".ready"}, cmd_ready, er);
        chk({tag, ".busy"}, busy, eb);
        chk({tag, ".done"}, done, ed);
    endtask

    task automatic step_chk(input string tag, input logic eo, input logic er,
                            input logic eb, input logic ed);
        step();
        chk_all(tag, eo, er, eb, ed);
    endtask

    initial begin
        // Reset state while rst is high
        #1;
        chk_all("rst", 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        chk_all("rst_hold", 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Idle after release
        for (int i = 0; i < 4; i++) step_chk("idle", 1'b0, 1'b1, 1'b0, 1'b0);
        chk("idle.y", y, 1'b0);

        // SET1 then queued SET0, valid held
        cmd_valid = 1'b1;
        cmd_op    = OP_SET1;
        step_chk("set1.e0", 1'b1, 1'b0, 1'b1, 1'b0);
        cmd_op = OP_SET0;  // ignored until ready
        step_chk("set1.e1", 1'b1, 1'b0, 1'b1, 1'b0);
        step_chk("set1.e2", 1'b1, 1'b0, 1'b1, 1'b0);
        step_chk("set1.e3", 1'b1, 1'b1, 1'b1, 1'b1);
        chk("set1.y_rise", y, 1'b1);
        step_chk("set0.e4", 1'b0, 1'b0, 1'b1, 1'b0);
        cmd_valid = 1'b0;
        step_chk("set0.e5", 1'b0, 1'b0, 1'b1, 1'b0);
        step_chk("set0.e6", 1'b0, 1'b0, 1'b1, 1'b0);
        step_chk("set0.e7", 1'b0, 1'b1, 1'b1, 1'b1);
        chk("set0.y_fall", y, 1'b0);
        step_chk("set0.e8", 1'b0, 1'b1, 1'b0, 1'b0);

        // PULSE from o=0
        cmd_valid = 1'b1;
        cmd_op    = OP_PULSE;
        step_chk("pls.e0", 1'b1, 1'b0, 1'b1, 1'b0);
        cmd_valid = 1'b0;
        step_chk("pls.e1", 1'b1, 1'b0, 1'b1, 1'b0);
        step_chk("pls.e2", 1'b1, 1'b0, 1'b1, 1'b0);
        step_chk("pls.e3", 1'b1, 1'b0, 1'b1, 1'b0);
        chk("pls.y_hi", y, 1'b1);
        step_chk("pls.e4", 1'b0, 1'b0, 1'b1, 1'b0);
        step_chk("pls.e5", 1'b0, 1'b0, 1'b1, 1'b0);
        step_chk("pls.e6", 1'b0, 1'b0, 1'b1, 1'b0);
        step_chk("pls.e7", 1'b0, 1'b1, 1'b1, 1'b1);
        chk("pls.y_lo", y, 1'b0);
        step_chk("pls.e8", 1'b0, 1'b1, 1'b0, 1'b0);

        // Redundant SET0 and NOP: immediate done, line untouched
        cmd_valid = 1'b1;
        cmd_op    = OP_SET0;
        step_chk("red.set0", 1'b0, 1'b1, 1'b0, 1'b1);
        cmd_op = OP_NOP;
        step_chk("red.nop", 1'b0, 1'b1, 1'b0, 1'b1);
        cmd_valid = 1'b0;
        step_chk("red.after", 1'b0, 1'b1, 1'b0, 1'b0);
        chk("red.y", y, 1'b0);

        // Bring the line high, then PULSE from o=1
        cmd_valid = 1'b1;
        cmd_op    = OP_SET1;
        step_chk("pre.set1", 1'b1, 1'b0, 1'b1, 1'b0);
        cmd_valid = 1'b0;
        step();
        step();
        step_chk("pre.e3", 1'b1, 1'b1, 1'b1, 1'b1);
        step_chk("pre.e4", 1'b1, 1'b1, 1'b0, 1'b0);
        cmd_valid = 1'b1;
        cmd_op    = OP_PULSE;
        step_chk("pp.e0", 1'b0, 1'b0, 1'b1, 1'b0);
        cmd_valid = 1'b0;
        step_chk("pp.e1", 1'b0, 1'b0, 1'b1, 1'b0);
        step_chk("pp.e2", 1'b0, 1'b0, 1'b1, 1'b0);
        step_chk("pp.e3", 1'b0, 1'b0, 1'b1, 1'b0);
        step_chk("pp.e4", 1'b1, 1'b0, 1'b1, 1'b0);
        step_chk("pp.e5", 1'b1, 1'b0, 1'b1, 1'b0);
        step_chk("pp.e6", 1'b1, 1'b0, 1'b1, 1'b0);
        step_chk("pp.e7", 1'b1, 1'b0, 1'b1, 1'b0);
        step_chk("pp.e8", 1'b0, 1'b0, 1'b1, 1'b0);
        step_chk("pp.e9", 1'b0, 1'b0, 1'b1, 1'b0);
        step_chk("pp.e10", 1'b0, 1'b0, 1'b1, 1'b0);
        step_chk("pp.e11", 1'b0, 1'b1, 1'b1, 1'b1);
        step_chk("pp.e12", 1'b0, 1'b1, 1'b0, 1'b0);

        // Reset in the middle of the high phase
        cmd_valid = 1'b1;
        cmd_op    = OP_PULSE;
        step_chk("rpl.e0", 1'b1, 1'b0, 1'b1, 1'b0);
        cmd_valid = 1'b0;
        step_chk("rpl.e1", 1'b1, 1'b0, 1'b1, 1'b0);
        rst = 1'b1;
        #1;
        chk_all("rpl.async", 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        @(negedge clk);
        rst = 1'b0;
        chk_all("rpl.released", 1'b0, 1'b1, 1'b0, 1'b0);
        cmd_valid = 1'b1;
        cmd_op    = OP_SET1;
        step_chk("rpl.set1", 1'b1, 1'b0, 1'b1, 1'b0);
        cmd_valid = 1'b0;
        step();
        step();
        step_chk("rpl.e3", 1'b1, 1'b1, 1'b1, 1'b1);
        step_chk("rpl.e4", 1'b1, 1'b1, 1'b0, 1'b0);
        chk("rpl.y", y, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
